oclib_uart_tx_arbiter: RTL and testbench

Shares one UART transmit byte channel among several requesters, granting one requester at a time for a whole message and rotating priority round-robin. It sits between multiple producers (debug console, status reporter, command responder) and the byte input of the UART transmit path, so messages from different sources never interleave on the wire. An idle-timeout forcibly releases a requester that stalls mid-message.

---
 rtl/oclib_uart_tx_arbiter.sv | 150 +++++++++++++++
 tb/tb_oclib_uart_tx_arbiter.sv | 363 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/oclib_uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : oclib_uart_tx_arbiter
// Brief    : Message-granular round-robin arbiter for a shared UART TX byte
//            channel, with idle-timeout forced release of a stalled holder.
// Revision : 1.0 - initial release
// ============================================================================
module oclib_uart_tx_arbiter #(
    parameter int Requesters        = 2,
    parameter int IdleTimeoutCycles = 1_000_000,
    parameter int GrantWidth        = (Requesters > 1) ? $clog2(Requesters) : 1
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [Requesters*8-1:0] reqData,
    input  logic [Requesters-1:0]   reqValid,
    input  logic [Requesters-1:0]   reqLast,
    output logic [Requesters-1:0]   reqReady,
    output logic [7:0]              txData,
    output logic                    txValid,
    input  logic                    txReady,
    output logic [GrantWidth-1:0]   grantId,
    output logic                    busy,
    output logic                    errorTimeout
);

    localparam int c_CNT_W = (IdleTimeoutCycles > 0) ? $clog2(IdleTimeoutCycles + 1) : 1;
    localparam logic [c_CNT_W-1:0]    c_THRESH  = c_CNT_W'(IdleTimeoutCycles);
    localparam logic                  c_TO_EN   = (IdleTimeoutCycles != 0);
    localparam logic [GrantWidth-1:0] c_LAST_ID = GrantWidth'(Requesters - 1);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [GrantWidth-1:0] r_grant;
    logic [GrantWidth-1:0] w_grant_nxt;
    logic [GrantWidth-1:0] r_rr_ptr;
    logic [GrantWidth-1:0] w_rr_nxt;
    logic [GrantWidth-1:0] w_grant_inc;
    logic [GrantWidth-1:0] w_sel;
    logic [GrantWidth-1:0] w_cand;
    logic                  w_found;
    int                    w_rr_idx;
    logic [c_CNT_W-1:0]    r_idle_cnt;
    logic [c_CNT_W-1:0]    w_cnt_nxt;
    logic [c_CNT_W-1:0]    w_cnt_inc;
    logic                  r_err;
    logic                  w_err_nxt;
    logic                  w_xfer;
    logic [7:0]            w_bytes [Requesters];

    generate
        for (genvar gi = 0; gi < Requesters; gi++) begin : g_unpack
            assign w_bytes[gi] = reqData[gi*8 +: 8];
        end
    endgenerate

    // First valid requester at or above the round-robin pointer, wrapping.
    always_comb begin
        w_found  = 1'b0;
        w_sel    = '0;
        w_rr_idx = 0;
        w_cand   = '0;
        for (int k = 0; k < Requesters; k++) begin
            w_rr_idx = int'(r_rr_ptr) + k;
            if (w_rr_idx >= Requesters) begin
                w_rr_idx = w_rr_idx - Requesters;
            end
            w_cand = GrantWidth'(w_rr_idx);
            if (!w_found && reqValid[w_cand]) begin
                w_found = 1'b1;
                w_sel   = w_cand;
            end
        end
    end

    assign w_grant_inc = (r_grant == c_LAST_ID) ? '0 : r_grant + 1'b1;
    assign w_cnt_inc   = (&r_idle_cnt) ? r_idle_cnt : r_idle_cnt + 1'b1;

    always_comb begin
        txData      = w_bytes[r_grant];
        txValid     = 1'b0;
        reqReady    = '0;
        w_state_nxt = r_state;
        w_grant_nxt = r_grant;
        w_rr_nxt    = r_rr_ptr;
        w_cnt_nxt   = r_idle_cnt;
        w_err_nxt   = 1'b0;
        if (r_state == GRANT) begin
            txValid           = reqValid[r_grant];
            reqReady[r_grant] = txReady;
        end
        w_xfer = txValid && txReady;

        case (r_state)
            IDLE: begin
                if (w_found) begin
                    w_state_nxt = GRANT;
                    w_grant_nxt = w_sel;
                    w_cnt_nxt   = '0;
                end
            end
            GRANT: begin
                if (w_xfer) begin
                    w_cnt_nxt = '0;
                    if (reqLast[r_grant]) begin
                        w_state_nxt = IDLE;
                        w_rr_nxt    = w_grant_inc;
                    end
                end else begin
                    w_cnt_nxt = w_cnt_inc;
                    // Release fires on the cycle the count reaches the threshold,
                    // so the pulse lands on the first IDLE cycle.
                    if (c_TO_EN && (w_cnt_inc == c_THRESH)) begin
                        w_state_nxt = IDLE;
                        w_rr_nxt    = w_grant_inc;
                        w_err_nxt   = 1'b1;
                    end
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state    <= IDLE;
            r_grant    <= '0;
            r_rr_ptr   <= '0;
            r_idle_cnt <= '0;
            r_err      <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_grant    <= w_grant_nxt;
            r_rr_ptr   <= w_rr_nxt;
            r_idle_cnt <= w_cnt_nxt;
            r_err      <= w_err_nxt;
        end
    end

    assign grantId      = r_grant;
    assign busy         = (r_state == GRANT);
    assign errorTimeout = r_err;

endmodule
`default_nettype wire

// File: tb/tb_oclib_uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_oclib_uart_tx_arbiter
// Brief    : Scoreboard bench for oclib_uart_tx_arbiter (2 requesters).
// Revision : 1.0 - initial release
// ============================================================================
module tb_oclib_uart_tx_arbiter;

    typedef struct {
        logic [7:0] data;
        logic       gid;
        int         gap;
    } exp_t;

    logic        clock = 1'b0;
    logic        reset;
    logic [15:0] reqData;
    logic [1:0]  reqValid;
    logic [1:0]  reqLast;
    logic [1:0]  reqReady;
    logic [7:0]  txData;
    logic        txValid;
    logic        txReady;
    logic [0:0]  grantId;
    logic        busy;
    logic        errorTimeout;

    logic [1:0]  reqReady_n;
    logic [7:0]  txData_n;
    logic        txValid_n;
    logic [0:0]  grantId_n;
    logic        busy_n;
    logic        errorTimeout_n;

    exp_t        exp_q[$];
    exp_t        mon_e;
    logic [8:0]  q0[$];
    logic [8:0]  q1[$];
    logic [1:0]  hs_s = 2'b00;
    int          n_checks = 0;
    int          n_pass = 0;
    int          cyc = 0;
    int          last_xfer = 0;

    always #5 clock = ~clock;

    oclib_uart_tx_arbiter #(.Requesters(2), .IdleTimeoutCycles(8)) dut (
        .clock(clock), .reset(reset), .reqData(reqData), .reqValid(reqValid),
        .reqLast(reqLast), .reqReady(reqReady), .txData(txData), .txValid(txValid),
        .txReady(txReady), .grantId(grantId), .busy(busy), .errorTimeout(errorTimeout)
    );

    oclib_uart_tx_arbiter #(.Requesters(2), .IdleTimeoutCycles(0)) dut_nto (
        .clock(clock), .reset(reset), .reqData(reqData), .reqValid(reqValid),
        .reqLast(reqLast), .reqReady(reqReady_n), .txData(txData_n), .txValid(txValid_n),
        .txReady(txReady), .grantId(grantId_n), .busy(busy_n), .errorTimeout(errorTimeout_n)
    );

    // Scoreboard: every wire transfer pops the next expected byte.
    always @(negedge clock) begin
        cyc  = cyc + 1;
        hs_s = reqValid & reqReady;
        if (!reset && txValid && txReady) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                $display("FAIL unexpected_xfer: got data=%h gid=%0d, required no transfer", txData, grantId);
            end else begin
                mon_e = exp_q.pop_front();
                if (txData !== mon_e.data || grantId !== mon_e.gid ||
                    (mon_e.gap >= 0 && (cyc - last_xfer) != mon_e.gap)) begin
                    $display("FAIL xfer: got data=%h gid=%0d gap=%0d, required data=%h gid=%0d gap=%0d",
                             txData, grantId, cyc - last_xfer, mon_e.data, mon_e.gid, mon_e.gap);
                end else begin
                    n_pass++;
                end
            end
            last_xfer = cyc;
        end
    end

    function automatic exp_t mk(input logic [7:0] d, input logic g, input int gap);
        exp_t e;
        e.data = d;
        e.gid  = g;
        e.gap  = gap;
        return e;
    endfunction

    task automatic drive();
        reqValid[0]  = (q0.size() != 0);
        reqData[7:0] = (q0.size() != 0) ? q0[0][7:0] : 8'h00;
        reqLast[0]   = (q0.size() != 0) ? q0[0][8] : 1'b0;
        reqValid[1]  = (q1.size() != 0);
        reqData[15:8] = (q1.size() != 0) ? q1[0][7:0] : 8'h00;
        reqLast[1]   = (q1.size() != 0) ? q1[0][8] : 1'b0;
    endtask

    task automatic cycle();
        @(posedge clock);
        #1;
        if (hs_s[0] && q0.size() != 0) q0.delete(0);
        if (hs_s[1] && q1.size() != 0) q1.delete(0);
        drive();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        q0.delete();
        q1.delete();
        exp_q.delete();
        txReady = 1'b1;
        drive();
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        q0 = {9'h1AA};
        q1 = {9'h1BB};
        drive();
        @(negedge clock);
        n_checks++;
        if ({busy, txValid, reqReady, grantId, errorTimeout} !== 6'b0)
            $display("FAIL reset_outputs: got %b, required 000000", {busy, txValid, reqReady, grantId, errorTimeout});
        else n_pass++;
        n_checks++;
        if ({busy_n, txValid_n, reqReady_n, grantId_n, errorTimeout_n} !== 6'b0)
            $display("FAIL reset_outputs_nto: got %b, required 000000", {busy_n, txValid_n, reqReady_n, grantId_n, errorTimeout_n});
        else n_pass++;
        do_reset();
    endtask

    task automatic test_single_source();
        do_reset();
        q0 = {9'h041, 9'h042, 9'h143};
        exp_q.push_back(mk(8'h41, 1'b0, -1));
        exp_q.push_back(mk(8'h42, 1'b0, 1));
        exp_q.push_back(mk(8'h43, 1'b0, 1));
        drive();
        @(negedge clock);
        n_checks++;
        if (txValid !== 1'b0) $display("FAIL idle_no_valid: got %b, required 0", txValid);
        else n_pass++;
        cycle();
        @(negedge clock);
        n_checks++;
        if ({txValid, busy, grantId} !== 3'b110) $display("FAIL grant_latency: got %b, required 110", {txValid, busy, grantId});
        else n_pass++;
        repeat (3) cycle();
        @(negedge clock);
        n_checks++;
        if (busy !== 1'b0) $display("FAIL busy_after_last: got %b, required 0", busy);
        else n_pass++;
        // Pointer should now favour requester 1.
        cycle();
        q0 = {9'h1A0};
        q1 = {9'h1A1};
        exp_q.push_back(mk(8'hA1, 1'b1, -1));
        exp_q.push_back(mk(8'hA0, 1'b0, 2));
        drive();
        for (int i = 0; i < 50 && exp_q.size() != 0; i++) cycle();
        n_checks++;
        if (exp_q.size() != 0) $display("FAIL single_drain: got %0d left, required 0", exp_q.size());
        else n_pass++;
    endtask

    task automatic test_round_robin();
        do_reset();
        for (int m = 0; m < 3; m++) begin
            q0.push_back(9'h010);
            q0.push_back(9'h111);
            q1.push_back(9'h020);
            q1.push_back(9'h121);
            exp_q.push_back(mk(8'h10, 1'b0, (m == 0) ? -1 : 2));
            exp_q.push_back(mk(8'h11, 1'b0, 1));
            exp_q.push_back(mk(8'h20, 1'b1, 2));
            exp_q.push_back(mk(8'h21, 1'b1, 1));
        end
        drive();
        for (int i = 0; i < 60 && exp_q.size() != 0; i++) cycle();
        n_checks++;
        if (exp_q.size() != 0) $display("FAIL rr_drain: got %0d left, required 0", exp_q.size());
        else n_pass++;
    endtask

    task automatic test_backpressure();
        int pat [8] = '{1, 0, 0, 1, 1, 0, 0, 1};
        do_reset();
        q1 = {9'h0C0, 9'h0C1, 9'h0C2, 9'h1C3};
        exp_q.push_back(mk(8'hC0, 1'b1, -1));
        exp_q.push_back(mk(8'hC1, 1'b1, 3));
        exp_q.push_back(mk(8'hC2, 1'b1, 1));
        exp_q.push_back(mk(8'hC3, 1'b1, 3));
        drive();
        for (int k = 0; k < 8; k++) begin
            cycle();
            txReady = pat[k][0];
            @(negedge clock);
            n_checks++;
            if (reqReady !== {txReady, 1'b0})
                $display("FAIL bp_ready k=%0d: got %b, required %b", k, reqReady, {txReady, 1'b0});
            else n_pass++;
        end
        txReady = 1'b1;
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) cycle();
        n_checks++;
        if (exp_q.size() != 0) $display("FAIL bp_drain: got %0d left, required 0", exp_q.size());
        else n_pass++;
    endtask

    task automatic test_timeout();
        do_reset();
        q0 = {9'h055};
        exp_q.push_back(mk(8'h55, 1'b0, -1));
        drive();
        cycle();
        for (int k = 1; k <= 12; k++) begin
            cycle();
            if (k == 2) begin
                q1 = {9'h166};
                exp_q.push_back(mk(8'h66, 1'b1, 10));
                drive();
            end
            @(negedge clock);
            n_checks++;
            if (errorTimeout !== (k == 9))
                $display("FAIL to_pulse k=%0d: got %b, required %b", k, errorTimeout, (k == 9));
            else n_pass++;
            n_checks++;
            if (busy !== ((k <= 8) || (k == 10)))
                $display("FAIL to_busy k=%0d: got %b, required %b", k, busy, ((k <= 8) || (k == 10)));
            else n_pass++;
        end
        n_checks++;
        if (exp_q.size() != 0) $display("FAIL to_drain: got %0d left, required 0", exp_q.size());
        else n_pass++;
    endtask

    task automatic test_timeout_boundary();
        int pulses = 0;
        do_reset();
        q0 = {9'h070};
        exp_q.push_back(mk(8'h70, 1'b0, -1));
        drive();
        cycle();
        for (int k = 1; k <= 10; k++) begin
            cycle();
            if (k == 8) begin
                q0.push_back(9'h171);
                exp_q.push_back(mk(8'h71, 1'b0, 8));
                drive();
            end
            @(negedge clock);
            if (errorTimeout) pulses++;
            if (k == 8) begin
                n_checks++;
                if ({busy, grantId} !== 2'b10) $display("FAIL bnd_busy: got %b, required 10", {busy, grantId});
                else n_pass++;
            end
        end
        n_checks++;
        if (pulses != 0) $display("FAIL bnd_pulse: got %0d pulses, required 0", pulses);
        else n_pass++;
        n_checks++;
        if (exp_q.size() != 0) $display("FAIL bnd_drain: got %0d left, required 0", exp_q.size());
        else n_pass++;
    endtask

    task automatic test_timeout_disabled();
        int pulses = 0;
        int drops  = 0;
        do_reset();
        q0 = {9'h0E0};
        exp_q.push_back(mk(8'hE0, 1'b0, -1));
        drive();
        cycle();
        for (int k = 1; k <= 1000; k++) begin
            cycle();
            @(negedge clock);
            if (errorTimeout_n) pulses++;
            if (!busy_n) drops++;
        end
        n_checks++;
        if (pulses != 0 || drops != 0 || grantId_n !== 1'b0)
            $display("FAIL nto_hold: got pulses=%0d drops=%0d gid=%0d, required 0 0 0", pulses, drops, grantId_n);
        else n_pass++;
        n_checks++;
        if (exp_q.size() != 0) $display("FAIL nto_drain: got %0d left, required 0", exp_q.size());
        else n_pass++;
    endtask

    task automatic test_async_reset();
        do_reset();
        q0 = {9'h1B0};
        exp_q.push_back(mk(8'hB0, 1'b0, -1));
        drive();
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) cycle();
        cycle();
        q1 = {9'h0D0, 9'h0D1, 9'h0D2, 9'h0D3, 9'h1D4};
        exp_q.push_back(mk(8'hD0, 1'b1, -1));
        drive();
        cycle();
        cycle();
        txReady = 1'b0;
        @(negedge clock);
        n_checks++;
        if ({txValid, busy, grantId} !== 3'b111) $display("FAIL ar_pre: got %b, required 111", {txValid, busy, grantId});
        else n_pass++;
        #2;
        txReady = 1'b1;
        reset   = 1'b1;
        #1;
        n_checks++;
        if ({busy, txValid, reqReady, grantId, errorTimeout} !== 6'b0)
            $display("FAIL ar_immediate: got %b, required 000000", {busy, txValid, reqReady, grantId, errorTimeout});
        else n_pass++;
        n_checks++;
        if (exp_q.size() != 0) $display("FAIL ar_pre_drain: got %0d left, required 0", exp_q.size());
        else n_pass++;
        q0.delete();
        q1.delete();
        exp_q.delete();
        drive();
        @(posedge clock);
        #1 reset = 1'b0;
        q0 = {9'h1F0};
        q1 = {9'h1F1};
        exp_q.push_back(mk(8'hF0, 1'b0, -1));
        exp_q.push_back(mk(8'hF1, 1'b1, 2));
        drive();
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) cycle();
        n_checks++;
        if (exp_q.size() != 0) $display("FAIL ar_drain: got %0d left, required 0", exp_q.size());
        else n_pass++;
    endtask

    initial begin
        reset    = 1'b1;
        txReady  = 1'b1;
        reqValid = 2'b00;
        reqLast  = 2'b00;
        reqData  = 16'h0000;
        test_reset();
        test_single_source();
        test_round_robin();
        test_backpressure();
        test_timeout();
        test_timeout_boundary();
        test_timeout_disabled();
        test_async_reset();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
